// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encodings, the
// default NOP instruction and the queue entry layout.
package if_fetch_ctrl_pkg;

   localparam logic [1:0] FS_IDLE = 2'd0;
   localparam logic [1:0] FS_BUSY = 2'd1;
   localparam logic [1:0] FS_DROP = 2'd2;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

   // Fetch addresses are word aligned; the low two bits are simply cleared.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & 32'hFFFF_FFFC;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/if_fetch_ctrl_fetch_queue.sv
// Small PC+instruction FIFO between the Icache response path and ID.
// Supports simultaneous push and pop when full; flush empties it in one cycle.
module fetch_queue
   import if_fetch_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fq_entry_t                push_entry,
   output fq_entry_t                head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   fq_entry_t       mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic            pop_ok;
   logic            push_ok;

   assign pop_ok  = pop && (count != '0);
   assign push_ok = push && ((count < CNT_FULL) || pop_ok);
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (push_ok && !pop_ok)
            count <= count + CW'(1);
         else if (pop_ok && !push_ok)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush)
         mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: one outstanding Icache request, queue of fetched
// instructions to ID, redirect flush with stale-response drop. FETCH_PERF_EN adds perf counters.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2,
   parameter logic [31:0] NOP_INST = INST_NOP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        ic_req_o,
   output logic [31:0] ic_addr_o,
   input  logic        ic_ready_i,
   input  logic [31:0] ic_inst_i,
   output logic        fq_valid_o,
   output logic [31:0] fq_inst_o,
   output logic [31:0] fq_pc_o,
   input  logic        id_ready_i
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_drop_cnt_o,
   output logic [31:0] perf_empty_cnt_o
`endif
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [31:0]   fetch_pc;
   logic [31:0]   fetch_pc_next;
   logic [31:0]   stale_addr;
   logic [31:0]   stale_addr_next;
   logic [CW-1:0] count;
   logic [CW-1:0] count_after_pop;
   logic          fq_valid;
   logic          push;
   logic          pop;
   fq_entry_t     push_entry;
   fq_entry_t     head;

   assign fq_valid        = (count != '0);
   assign pop             = fq_valid && id_ready_i && !redirect_i;
   assign push            = (state == FS_BUSY) && ic_ready_i && !redirect_i;
   assign push_entry      = '{pc: fetch_pc, inst: ic_inst_i};
   assign count_after_pop = count - CW'(pop);

   fetch_queue #(
      .DEPTH(QDEPTH)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .pop        (pop),
      .flush      (redirect_i),
      .push_entry (push_entry),
      .head       (head),
      .count      (count)
   );

   // A redirect with a request still in flight must swallow exactly one
   // response, so DROP keeps the old address on the bus while fetch_pc moves on.
   always_comb begin
      state_next      = state;
      fetch_pc_next   = fetch_pc;
      stale_addr_next = stale_addr;
      if (redirect_i) begin
         fetch_pc_next = align_pc(redirect_pc_i);
         if ((state != FS_IDLE) && !ic_ready_i) begin
            state_next = FS_DROP;
            if (state == FS_BUSY)
               stale_addr_next = fetch_pc;
         end else begin
            state_next = FS_BUSY;
         end
      end else begin
         case (state)
            FS_IDLE: begin
               if (count_after_pop < CNT_FULL)
                  state_next = FS_BUSY;
            end
            FS_BUSY: begin
               if (ic_ready_i) begin
                  fetch_pc_next = fetch_pc + 32'd4;
                  state_next    = ((count_after_pop + CW'(1)) < CNT_FULL) ? FS_BUSY : FS_IDLE;
               end
            end
            FS_DROP: begin
               if (ic_ready_i)
                  state_next = FS_BUSY;
            end
            default: state_next = FS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FS_IDLE;
         fetch_pc   <= RESET_PC;
         stale_addr <= RESET_PC;
      end else begin
         state      <= state_next;
         fetch_pc   <= fetch_pc_next;
         stale_addr <= stale_addr_next;
      end
   end

   assign ic_req_o   = (state != FS_IDLE);
   assign ic_addr_o  = (state == FS_DROP) ? stale_addr : fetch_pc;
   assign fq_valid_o = fq_valid;
   assign fq_inst_o  = fq_valid ? head.inst : NOP_INST;
   assign fq_pc_o    = fq_valid ? head.pc : 32'h0;

`ifdef FETCH_PERF_EN
   logic drop_evt;
   logic empty_evt;

   // A discarded response is either the stale one in DROP or one that
   // lands in the same cycle as a redirect.
   assign drop_evt  = ic_ready_i && ((state == FS_DROP) || ((state == FS_BUSY) && redirect_i));
   assign empty_evt = id_ready_i && !fq_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_drop_cnt_o  <= 32'h0;
         perf_empty_cnt_o <= 32'h0;
      end else begin
         if (drop_evt)
            perf_drop_cnt_o <= sat_inc(perf_drop_cnt_o);
         if (empty_evt)
            perf_empty_cnt_o <= sat_inc(perf_empty_cnt_o);
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed vector table, hand-written
// redirect sequences and a randomized run against a queue-based reference model.
module tb_if_fetch_ctrl;

   localparam int          QDEPTH = 2;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        ic_req_o;
   logic [31:0] ic_addr_o;
   logic        ic_ready_i;
   logic [31:0] ic_inst_i;
   logic        fq_valid_o;
   logic [31:0] fq_inst_o;
   logic [31:0] fq_pc_o;
   logic        id_ready_i;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_drop_cnt_o;
   logic [31:0] perf_empty_cnt_o;
`endif

   int n_cmp;
   int n_fail;

   if_fetch_ctrl #(
      .RESET_PC (32'h0),
      .QDEPTH   (QDEPTH),
      .NOP_INST (NOP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .ic_req_o      (ic_req_o),
      .ic_addr_o     (ic_addr_o),
      .ic_ready_i    (ic_ready_i),
      .ic_inst_i     (ic_inst_i),
      .fq_valid_o    (fq_valid_o),
      .fq_inst_o     (fq_inst_o),
      .fq_pc_o       (fq_pc_o),
      .id_ready_i    (id_ready_i)
`ifdef FETCH_PERF_EN
      ,
      .perf_drop_cnt_o  (perf_drop_cnt_o),
      .perf_empty_cnt_o (perf_empty_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      logic [31:0] inst;
      logic        idr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   vec_t tbl [9];

   // Reference model state: request flag, stale flag and a plain queue of {pc, inst}.
   logic        m_pending;
   logic        m_stale;
   logic [31:0] m_fpc;
   logic [31:0] m_saddr;
   logic [63:0] m_q [$];
   logic [31:0] m_drops;
   logic [31:0] m_empty;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic redir, input logic [31:0] rpc, input logic rdy,
                                 input logic [31:0] inst, input logic idr);
      redirect_i    = redir;
      redirect_pc_i = rpc;
      ic_ready_i    = rdy;
      ic_inst_i     = inst;
      id_ready_i    = idr;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pc, input logic [31:0] inst);
      check_output({tag, " req"}, 32'(ic_req_o), 32'(req));
      if (req)
         check_output({tag, " addr"}, ic_addr_o, addr);
      check_output({tag, " valid"}, 32'(fq_valid_o), 32'(valid));
      if (valid) begin
         check_output({tag, " pc"}, fq_pc_o, pc);
         check_output({tag, " inst"}, fq_inst_o, inst);
      end else begin
         check_output({tag, " inst"}, fq_inst_o, NOP);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n         = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      ic_ready_i    = 1'b0;
      ic_inst_i     = 32'h0;
      id_ready_i    = 1'b0;
      #2;
      check_output("rst req", 32'(ic_req_o), 32'h0);
      check_output("rst addr", ic_addr_o, 32'h0);
      check_output("rst valid", 32'(fq_valid_o), 32'h0);
      check_output("rst inst", fq_inst_o, NOP);
      check_output("rst pc", fq_pc_o, 32'h0);
`ifdef FETCH_PERF_EN
      check_output("rst perf_drop", perf_drop_cnt_o, 32'h0);
      check_output("rst perf_empty", perf_empty_cnt_o, 32'h0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic model_step(input logic redir, input logic [31:0] rpc, input logic rdy,
                             input logic [31:0] inst, input logic idr);
      if (idr && (m_q.size() == 0))
         m_empty++;
      if (redir) begin
         if (m_pending && rdy)
            m_drops++;
         if (m_pending && !rdy) begin
            if (!m_stale)
               m_saddr = m_fpc;
            m_stale = 1'b1;
         end else begin
            m_stale = 1'b0;
         end
         m_pending = 1'b1;
         m_fpc     = rpc & 32'hFFFF_FFFC;
         m_q.delete();
      end else begin
         if (idr && (m_q.size() > 0))
            void'(m_q.pop_front());
         if (m_stale) begin
            if (rdy) begin
               m_stale = 1'b0;
               m_drops++;
            end
         end else if (m_pending) begin
            if (rdy) begin
               m_q.push_back({m_fpc, inst});
               m_fpc     = m_fpc + 32'd4;
               m_pending = (m_q.size() < QDEPTH);
            end
         end else begin
            m_pending = (m_q.size() < QDEPTH);
         end
      end
   endtask

   initial begin
      logic        r_redir;
      logic [31:0] r_rpc;
      logic        r_rdy;
      logic [31:0] r_inst;
      logic        r_idr;
      logic [63:0] head;

      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;

      // Back-pressure fills the two-entry queue, then release drains it at one per clock.
      tbl[0] = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  1'b0, 32'h0, NOP};
      tbl[1] = '{1'b0, 32'h0, 1'b1, 32'hA000_0000, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0, NOP};
      tbl[2] = '{1'b0, 32'h0, 1'b1, 32'hA000_0004, 1'b0, 1'b1, 32'h4,  1'b1, 32'h0, 32'hA000_0000};
      tbl[3] = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8,  1'b1, 32'h0, 32'hA000_0000};
      tbl[4] = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8,  1'b1, 32'h0, 32'hA000_0000};
      tbl[5] = '{1'b0, 32'h0, 1'b1, 32'hA000_0008, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4, 32'hA000_0004};
      tbl[6] = '{1'b0, 32'h0, 1'b1, 32'hA000_000C, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8, 32'hA000_0008};
      tbl[7] = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 32'hA000_000C};
      tbl[8] = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10, 1'b0, 32'h0, NOP};

      do_reset();
      for (int i = 0; i < 9; i++) begin
         expect_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                    tbl[i].e_pc, tbl[i].e_inst);
         apply_stimulus(tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].inst, tbl[i].idr);
      end

      // Redirect during a slow response: the stale response must be swallowed.
      do_reset();
      expect_out("s3a", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_out("s3b", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_out("s3c", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
      apply_stimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      expect_out("s3d", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_out("s3e", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
      apply_stimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_0000, 1'b0);
      expect_out("s3f", 1'b1, 32'h100, 1'b0, 32'h0, NOP);
      apply_stimulus(1'b0, 32'h0, 1'b1, 32'hA000_0100, 1'b0);
      expect_out("s3g", 1'b1, 32'h104, 1'b1, 32'h100, 32'hA000_0100);
`ifdef FETCH_PERF_EN
      check_output("s3 perf_drop", perf_drop_cnt_o, 32'd1);
`endif

      // Redirect coinciding with a response while one entry is queued.
      apply_stimulus(1'b1, 32'h100, 1'b1, 32'hBAD0_0000, 1'b1);
      expect_out("s4", 1'b1, 32'h100, 1'b0, 32'h0, NOP);
`ifdef FETCH_PERF_EN
      check_output("s4 perf_drop", perf_drop_cnt_o, 32'd2);
`endif

      // Two redirects against one outstanding request; second target unaligned.
      apply_stimulus(1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
      expect_out("s5a", 1'b1, 32'h100, 1'b0, 32'h0, NOP);
      apply_stimulus(1'b1, 32'h303, 1'b0, 32'h0, 1'b0);
      expect_out("s5b", 1'b1, 32'h100, 1'b0, 32'h0, NOP);
      apply_stimulus(1'b0, 32'h0, 1'b1, 32'hBAD0_0001, 1'b0);
      expect_out("s5c", 1'b1, 32'h300, 1'b0, 32'h0, NOP);
      apply_stimulus(1'b0, 32'h0, 1'b1, 32'hA000_0300, 1'b0);
      expect_out("s5d", 1'b1, 32'h304, 1'b1, 32'h300, 32'hA000_0300);

      // fetch_pc wraps from the top of the address space to zero.
      apply_stimulus(1'b1, 32'hFFFF_FFFE, 1'b1, 32'hBAD0_0002, 1'b0);
      expect_out("wrap a", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP);
      apply_stimulus(1'b0, 32'h0, 1'b1, 32'hA000_FFFC, 1'b0);
      expect_out("wrap b", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hA000_FFFC);
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      expect_out("wrap c", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
`ifdef FETCH_PERF_EN
      check_output("s5 perf_drop", perf_drop_cnt_o, 32'd4);
`endif

      // Reset asserted with a request outstanding (checked inside do_reset).
      do_reset();
`ifdef FETCH_PERF_EN
      for (int i = 0; i < 5; i++)
         apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check_output("perf_empty 5", perf_empty_cnt_o, 32'd5);
      do_reset();
`endif

      // Randomized run against the reference model.
      m_pending = 1'b0;
      m_stale   = 1'b0;
      m_fpc     = 32'h0;
      m_saddr   = 32'h0;
      m_drops   = 32'h0;
      m_empty   = 32'h0;
      m_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         check_output("rnd req", 32'(ic_req_o), 32'(m_pending));
         if (m_pending)
            check_output("rnd addr", ic_addr_o, m_stale ? m_saddr : m_fpc);
         check_output("rnd valid", 32'(fq_valid_o), 32'(m_q.size() != 0));
         if (m_q.size() != 0) begin
            head = m_q[0];
            check_output("rnd pc", fq_pc_o, head[63:32]);
            check_output("rnd inst", fq_inst_o, head[31:0]);
         end else begin
            check_output("rnd inst", fq_inst_o, NOP);
         end
         r_redir = ($urandom_range(0, 9) == 0);
         r_rpc   = $urandom;
         if ($urandom_range(0, 4) == 0)
            r_rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         r_rdy   = m_pending && ($urandom_range(0, 2) != 0);
         r_inst  = $urandom;
         r_idr   = ($urandom_range(0, 3) != 0);
         model_step(r_redir, r_rpc, r_rdy, r_inst, r_idr);
         apply_stimulus(r_redir, r_rpc, r_rdy, r_inst, r_idr);
      end
`ifdef FETCH_PERF_EN
      check_output("rnd perf_drop", perf_drop_cnt_o, m_drops);
      check_output("rnd perf_empty", perf_empty_cnt_o, m_empty);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
